// File: rtl/tqvp_bus_initiator.sv
// Purpose: host-side initiator for the TinyQV peripheral bus, one transaction per command.
// Latency: write or immediate-ready read responds 2 cycles after accept; read timeout after TIMEOUT+1.
// Backpressure: req_ready only in IDLE; response is held stable in RESP until rsp_ready.
module tqvp_bus_initiator #(
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] bus_address,
    output logic [31:0]       bus_data_in,
    output logic [1:0]        bus_data_write_n,
    output logic [1:0]        bus_data_read_n,
    input  logic [31:0]       bus_data_out,
    input  logic              bus_data_ready,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0] STROBE_OFF = 2'b11;
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] timer;

    // Zero-extend read data to the access size; 32-bit (and anything else) passes through.
    function automatic logic [31:0] size_mask(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'b00:   size_mask = {24'h0, d[7:0]};
            2'b01:   size_mask = {16'h0, d[15:0]};
            default: size_mask = d;
        endcase
    endfunction

    wire read_done    = bus_data_ready;
    wire read_timeout = (timer == TIMER_LAST);

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    // State register; reset drops any in-flight transaction or pending response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode: illegal size skips the bus, WRITE is a single cycle, READ waits or times out.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_size == 2'b11) state_nxt = RESP;
                    else if (req_write)    state_nxt = WRITE;
                    else                   state_nxt = READ;
                end
            end
            WRITE:   state_nxt = RESP;
            READ:    if (read_done || read_timeout) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered bus strobes, held address/data, read timer and response payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_address      <= '0;
            bus_data_in      <= '0;
            bus_data_write_n <= STROBE_OFF;
            bus_data_read_n  <= STROBE_OFF;
            timer            <= '0;
            rsp_rdata        <= '0;
            rsp_err          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        bus_address <= req_addr;
                        bus_data_in <= req_wdata;
                        timer       <= '0;
                        rsp_rdata   <= '0;
                        rsp_err     <= (req_size == 2'b11);
                        if (req_size != 2'b11) begin
                            if (req_write) bus_data_write_n <= req_size;
                            else           bus_data_read_n  <= req_size;
                        end
                    end
                end
                WRITE: begin
                    bus_data_write_n <= STROBE_OFF;
                    rsp_rdata        <= '0;
                    rsp_err          <= 1'b0;
                end
                READ: begin
                    if (read_done) begin
                        bus_data_read_n <= STROBE_OFF;
                        rsp_rdata       <= size_mask(bus_data_read_n, bus_data_out);
                        rsp_err         <= 1'b0;
                    end else if (read_timeout) begin
                        bus_data_read_n <= STROBE_OFF;
                        rsp_rdata       <= '0;
                        rsp_err         <= 1'b1;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tqvp_bus_initiator.sv
// Purpose: self-checking bench for tqvp_bus_initiator with a response scoreboard and a strobe monitor.
// Latency: responses are matched in order as they handshake, independent of stimulus timing.
// Backpressure: rsp_ready is held low in one scenario to check response stability.
module tb_tqvp_bus_initiator;
    localparam int ADDR_W  = 6;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [1:0]        req_size = 2'b00;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [31:0]       req_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] bus_address;
    logic [31:0]       bus_data_in;
    logic [1:0]        bus_data_write_n;
    logic [1:0]        bus_data_read_n;
    logic [31:0]       bus_data_out;
    logic              bus_data_ready;
    logic              busy;

    tqvp_bus_initiator #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .bus_address(bus_address), .bus_data_in(bus_data_in),
        .bus_data_write_n(bus_data_write_n), .bus_data_read_n(bus_data_read_n),
        .bus_data_out(bus_data_out), .bus_data_ready(bus_data_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int n_chk = 0;
    int n_err = 0;
    int n_rsp = 0;
    int n_exp = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int rd_run = 0;
    int rdy_mode = 0;   // 0: always ready, -1: never ready, N>0: ready in Nth read cycle
    logic [31:0]       data_good = 32'hA5C3_1234;
    logic [1:0]        exp_size = 2'b00;
    logic [ADDR_W-1:0] exp_addr = '0;
    logic [31:0]       exp_wdata = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Peripheral model: counts consecutive read-strobe cycles to decide when to raise data_ready.
    always @(posedge clk) rd_run <= (bus_data_read_n != 2'b11) ? rd_run + 1 : 0;

    always_comb begin
        bus_data_ready = 1'b0;
        if (rdy_mode == 0)       bus_data_ready = 1'b1;
        else if (rdy_mode > 0)   bus_data_ready = (bus_data_read_n != 2'b11) && (rd_run == rdy_mode - 1);
        bus_data_out = bus_data_ready ? data_good : 32'hDEAD_BEEF;
    end

    // Strobe monitor: counts active strobe cycles and checks what is driven while they are active.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_data_write_n != 2'b11) begin
                wr_cnt++;
                check("wr_strobe", {30'h0, bus_data_write_n}, {30'h0, exp_size});
                check("wr_addr", 32'(bus_address), 32'(exp_addr));
                check("wr_data", bus_data_in, exp_wdata);
                check("wr_no_rd", {30'h0, bus_data_read_n}, 32'h3);
            end
            if (bus_data_read_n != 2'b11) begin
                rd_cnt++;
                check("rd_strobe", {30'h0, bus_data_read_n}, {30'h0, exp_size});
                check("rd_addr", 32'(bus_address), 32'(exp_addr));
            end
        end
    end

    // Response monitor: pops the scoreboard on every response handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rsp_valid && rsp_ready) begin
            n_rsp++;
            if (sb.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_rsp: got rdata 0x%08h err %0d with empty scoreboard", rsp_rdata, rsp_err);
            end else begin
                e = sb.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
                check("rsp_strobes", {28'h0, bus_data_write_n, bus_data_read_n}, 32'hF);
                check("rsp_req_ready", {31'h0, req_ready}, 32'h0);
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the accept edge.
    task automatic issue(input logic w, input logic [1:0] size, input logic [ADDR_W-1:0] addr,
                         input logic [31:0] wdata, input bit push, input logic [31:0] erd, input logic eerr);
        int b;
        exp_t e;
        exp_size = size;
        exp_addr = addr;
        exp_wdata = wdata;
        wr_cnt = 0;
        rd_cnt = 0;
        if (push) begin
            e.rdata = erd;
            e.err = eerr;
            sb.push_back(e);
            n_exp++;
        end
        b = 0;
        while (!req_ready && b < 50) begin
            @(posedge clk); #1;
            b++;
        end
        check("req_ready_wait", {31'h0, req_ready}, 32'h1);
        req_write = w;
        req_size = size;
        req_addr = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int b;
        b = 0;
        while (n_rsp < n_exp && b < 100) begin
            @(posedge clk); #1;
            b++;
        end
        check("rsp_arrived", 32'(n_rsp), 32'(n_exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        check("rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_addr", 32'(bus_address), 32'h0);
        check("rst_data_in", bus_data_in, 32'h0);
        check("rst_strobes", {28'h0, bus_data_write_n, bus_data_read_n}, 32'hF);
        check("rst_busy", {31'h0, busy}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 32-bit write
        issue(1'b1, 2'b10, 6'h00, 32'h6000_0000, 1'b1, 32'h0, 1'b0);
        wait_rsp();
        check("w32_wr_cycles", 32'(wr_cnt), 32'd1);
        check("w32_rd_cycles", 32'(rd_cnt), 32'd0);

        // 8-bit write
        issue(1'b1, 2'b00, 6'h05, 32'h0000_00AB, 1'b1, 32'h0, 1'b0);
        wait_rsp();
        check("w8_wr_cycles", 32'(wr_cnt), 32'd1);

        // Reads with data_ready tied high
        rdy_mode = 0;
        data_good = 32'hA5C3_1234;
        issue(1'b0, 2'b00, 6'h01, 32'h0, 1'b1, 32'h0000_0034, 1'b0);
        wait_rsp();
        check("r8_rd_cycles", 32'(rd_cnt), 32'd1);
        issue(1'b0, 2'b01, 6'h02, 32'h0, 1'b1, 32'h0000_1234, 1'b0);
        wait_rsp();
        check("r16_rd_cycles", 32'(rd_cnt), 32'd1);
        issue(1'b0, 2'b10, 6'h03, 32'h0, 1'b1, 32'hA5C3_1234, 1'b0);
        wait_rsp();
        check("r32_rd_cycles", 32'(rd_cnt), 32'd1);
        check("r32_wr_cycles", 32'(wr_cnt), 32'd0);

        // Slow peripheral: ready in the 5th read cycle
        rdy_mode = 5;
        data_good = 32'h1122_3344;
        issue(1'b0, 2'b10, 6'h2A, 32'h0, 1'b1, 32'h1122_3344, 1'b0);
        wait_rsp();
        check("slow_rd_cycles", 32'(rd_cnt), 32'd5);

        // Timeout
        rdy_mode = -1;
        issue(1'b0, 2'b01, 6'h3F, 32'h0, 1'b1, 32'h0, 1'b1);
        wait_rsp();
        check("tmo_rd_cycles", 32'(rd_cnt), 32'(TIMEOUT));

        // Illegal size with response back-pressure
        rdy_mode = 0;
        rsp_ready = 1'b0;
        issue(1'b0, 2'b11, 6'h11, 32'h0, 1'b1, 32'h0, 1'b1);
        for (int b = 0; b < 20 && !rsp_valid; b++) begin
            @(posedge clk); #1;
        end
        check("ill_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", {31'h0, rsp_valid}, 32'h1);
            check("bp_rsp_err", {31'h0, rsp_err}, 32'h1);
            check("bp_rsp_rdata", rsp_rdata, 32'h0);
            check("bp_req_ready", {31'h0, req_ready}, 32'h0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_rsp();
        check("ill_wr_cycles", 32'(wr_cnt), 32'd0);
        check("ill_rd_cycles", 32'(rd_cnt), 32'd0);

        // Reset during READ, response dropped
        rdy_mode = -1;
        issue(1'b0, 2'b10, 6'h07, 32'h0, 1'b0, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        check("pre_rst_rd_active", {30'h0, bus_data_read_n}, 32'h2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_strobes", {28'h0, bus_data_write_n, bus_data_read_n}, 32'hF);
        check("arst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("arst_busy", {31'h0, busy}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rdy_mode = 0;
        @(posedge clk); #1;
        issue(1'b1, 2'b01, 6'h15, 32'h0000_CAFE, 1'b1, 32'h0, 1'b0);
        wait_rsp();
        check("post_rst_wr_cycles", 32'(wr_cnt), 32'd1);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
